// File: rtl/clock_pkg.sv
//------------------------------------------------------------------------------
// clock_pkg
//   Constants shared by the clock user-interface blocks. adj_mode values are
//   common to key_adjust_ctrl and display_driver, so the field being edited is
//   the field that flashes.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

  localparam logic [1:0] ADJ_NONE = 2'd0;
  localparam logic [1:0] ADJ_HOUR = 2'd1;
  localparam logic [1:0] ADJ_MIN  = 2'd2;

  // Mode key cycles NORMAL -> HOUR -> MIN -> NORMAL.
  function automatic logic [1:0] next_adj_mode(input logic [1:0] cur);
    case (cur)
      ADJ_NONE: return ADJ_HOUR;
      ADJ_HOUR: return ADJ_MIN;
      default:  return ADJ_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
//------------------------------------------------------------------------------
// key_debounce
//   2-FF synchroniser plus counter debouncer for one raw pushbutton.
//   Ports:
//     clk_scan  in   1 kHz scan clock
//     rst_n     in   asynchronous active-low reset
//     key_raw   in   raw, bouncy, active-high button
//     key_level out  debounced level
//     key_press out  one-cycle pulse on a rising edge of key_level
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_scan,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d       = {sync_q[0], key_raw};
    level_prev_d = level_q;
    level_d      = level_q;
    cnt_d        = '0;
    // Count consecutive disagreements; the cycle whose count would reach
    // DEBOUNCE_MS flips the level and leaves the counter cleared.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_scan or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= sync_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
    end
  end

  assign key_level = level_q;
  assign key_press = level_q & ~level_prev_q;

endmodule

`default_nettype wire

// File: rtl/key_adjust_ctrl.sv
//------------------------------------------------------------------------------
// key_adjust_ctrl
//   Clock user-interface input stage: debounces the three buttons, runs the
//   adjust-mode FSM and produces single-cycle inc/dec step pulses with
//   long-press auto-repeat and an inactivity timeout back to NORMAL.
//   Ports:
//     clk_scan   in   1 kHz scan clock (1 cycle = 1 ms)
//     rst_n      in   asynchronous active-low reset
//     key_mode   in   raw mode button
//     key_inc    in   raw increment button
//     key_dec    in   raw decrement button
//     adj_mode   out  ADJ_NONE / ADJ_HOUR / ADJ_MIN
//     inc_pulse  out  one-cycle increment request
//     dec_pulse  out  one-cycle decrement request
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_adjust_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 600,
  parameter int REPEAT_MS     = 150,
  parameter int TIMEOUT_MS    = 10000
) (
  input  logic       clk_scan,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic [1:0] adj_mode,
  output logic       inc_pulse,
  output logic       dec_pulse
);

  localparam int               RPT_W      = $clog2(LONG_PRESS_MS + 1);
  localparam int               TMO_W      = $clog2(TIMEOUT_MS + 1);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(LONG_PRESS_MS);
  // After a repeat pulse, restarting here puts the next one REPEAT_MS later.
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(LONG_PRESS_MS - REPEAT_MS + 1);
  localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(TIMEOUT_MS);

  logic mode_press, inc_press, dec_press;
  logic inc_lvl, dec_lvl;
  logic mode_lvl_unused;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_mode (
    .clk_scan (clk_scan), .rst_n (rst_n), .key_raw (key_mode),
    .key_level(mode_lvl_unused), .key_press(mode_press)
  );
  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_inc (
    .clk_scan (clk_scan), .rst_n (rst_n), .key_raw (key_inc),
    .key_level(inc_lvl), .key_press(inc_press)
  );
  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_dec (
    .clk_scan (clk_scan), .rst_n (rst_n), .key_raw (key_dec),
    .key_level(dec_lvl), .key_press(dec_press)
  );

  logic [1:0]       mode_q, mode_d;
  logic             armed_q, armed_d;     // a step key is being auto-repeated
  logic             dir_inc_q, dir_inc_d; // which key armed the repeat
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;

  logic step_press;
  logic both_held;
  logic armed_held;

  always_comb begin
    mode_d     = mode_q;
    armed_d    = armed_q;
    dir_inc_d  = dir_inc_q;
    rpt_d      = rpt_q;
    tmo_d      = tmo_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    step_press = inc_press | dec_press;
    both_held  = inc_lvl & dec_lvl;
    armed_held = dir_inc_q ? inc_lvl : dec_lvl;

    if (mode_press) begin
      // Mode change wins over any step press in the same cycle.
      mode_d  = next_adj_mode(mode_q);
      armed_d = 1'b0;
      rpt_d   = '0;
      tmo_d   = (next_adj_mode(mode_q) == ADJ_NONE) ? '0 : TMO_ONE;
    end else if (mode_q == ADJ_NONE) begin
      armed_d = 1'b0;
      rpt_d   = '0;
      tmo_d   = '0;
    end else begin
      if (both_held) begin
        // Conflicting keys: stay silent; the survivor needs a fresh press.
        armed_d = 1'b0;
        rpt_d   = '0;
      end else if (step_press) begin
        // Both presses at once imply both_held, so these are exclusive here.
        inc_d     = inc_press;
        dec_d     = dec_press;
        armed_d   = 1'b1;
        dir_inc_d = inc_press;
        rpt_d     = RPT_ONE;
      end else if (armed_q && armed_held) begin
        if (rpt_q == RPT_FIRE) begin
          inc_d = dir_inc_q;
          dec_d = ~dir_inc_q;
          rpt_d = RPT_RELOAD;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end else begin
        armed_d = 1'b0;
        rpt_d   = '0;
      end

      // tmo counts cycles since the last press or step pulse.
      if (step_press || inc_d || dec_d) begin
        tmo_d = TMO_ONE;
      end else if (tmo_q == TMO_LIMIT) begin
        mode_d  = ADJ_NONE;
        tmo_d   = '0;
        armed_d = 1'b0;
        rpt_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_scan or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= ADJ_NONE;
      armed_q   <= 1'b0;
      dir_inc_q <= 1'b0;
      rpt_q     <= '0;
      tmo_q     <= '0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      armed_q   <= armed_d;
      dir_inc_q <= dir_inc_d;
      rpt_q     <= rpt_d;
      tmo_q     <= tmo_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
    end
  end

  assign adj_mode  = mode_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;

endmodule

`default_nettype wire
